// File: rtl/pwm_core.sv
// Duty-cycle PWM generator driven by an upstream advance strobe.
// Prescaled period counter with double-buffered duty updates applied at period boundaries.
module pwm_core #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  tick_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      duty_in,
    input  logic                  duty_load,
    output logic                  pwm_out,
    output logic                  period_start,
    output logic [WIDTH-1:0]      duty_active,
    output logic                  load_pending
);

    localparam logic [WIDTH-1:0]      CNT_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0]      CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRESC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] r_presc_cnt;
    logic [WIDTH-1:0]      r_cnt;
    logic [WIDTH-1:0]      r_pending;
    logic [WIDTH-1:0]      r_duty_active;
    logic                  r_load_pending;
    logic                  r_period_start;

    logic w_qtick;
    logic w_step;
    logic w_wrap;

    assign w_qtick = ena && tick_in;
    // >= so that lowering prescale below the running count steps on the next tick
    assign w_step  = w_qtick && (r_presc_cnt >= prescale);
    assign w_wrap  = w_step && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
        end else if (w_qtick) begin
            if (w_step) r_presc_cnt <= '0;
            else        r_presc_cnt <= r_presc_cnt + PRESC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_wrap;
            if (w_step) begin
                if (w_wrap) r_cnt <= '0;
                else        r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    // A load coinciding with the wrap bypasses the pending register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending      <= '0;
            r_duty_active  <= '0;
            r_load_pending <= 1'b0;
        end else if (duty_load) begin
            r_pending <= duty_in;
            if (w_wrap) begin
                r_duty_active  <= duty_in;
                r_load_pending <= 1'b0;
            end else begin
                r_load_pending <= 1'b1;
            end
        end else if (w_wrap && r_load_pending) begin
            r_duty_active  <= r_pending;
            r_load_pending <= 1'b0;
        end
    end

    assign pwm_out      = ena && (r_cnt < r_duty_active);
    assign period_start = r_period_start;
    assign duty_active  = r_duty_active;
    assign load_pending = r_load_pending;

endmodule

// File: tb/tb_pwm_core.sv
// Self-checking bench for pwm_core: directed scenarios plus random traffic,
// each cycle compared against an arithmetic model of period position and duty buffering.
module tb_pwm_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       tick_in;
    logic [3:0] prescale;
    logic [7:0] duty_in;
    logic       duty_load;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;
    logic       load_pending;

    int n_vec = 0;
    int n_err = 0;

    // model: position within the 255-step period, ticks since last step, duty buffers
    int m_pos = 0;
    int m_since = 0;
    int m_active = 0;
    int m_pending = 0;
    int m_lp = 0;
    int m_pstart = 0;

    always #5 clk = ~clk;

    pwm_core #(.WIDTH(8), .PRESCALE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .tick_in      (tick_in),
        .prescale     (prescale),
        .duty_in      (duty_in),
        .duty_load    (duty_load),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active),
        .load_pending (load_pending)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int wrap;
        wrap = 0;
        if (!rst_n) begin
            m_pos = 0; m_since = 0; m_active = 0; m_pending = 0; m_lp = 0; m_pstart = 0;
        end else begin
            if (ena && tick_in) begin
                if (m_since >= int'(prescale)) begin
                    m_since = 0;
                    m_pos = (m_pos + 1) % 255;
                    wrap = (m_pos == 0);
                end else begin
                    m_since++;
                end
            end
            m_pstart = wrap;
            if (duty_load) begin
                m_pending = int'(duty_in);
                if (wrap) begin
                    m_active = int'(duty_in);
                    m_lp = 0;
                end else begin
                    m_lp = 1;
                end
            end else if (wrap && m_lp) begin
                m_active = m_pending;
                m_lp = 0;
            end
        end
    endtask

    // one clock: drive, edge, update model, check all observable state
    task automatic cyc(input logic r, input logic e, input logic t, input logic ld,
                       input int ps, input int d);
        rst_n = r; ena = e; tick_in = t; duty_load = ld;
        prescale = 4'(ps); duty_in = 8'(d);
        @(posedge clk);
        model_edge();
        #1;
        chk("pwm_out", int'(pwm_out), (ena && (m_pos < m_active)) ? 1 : 0);
        chk("period_start", int'(period_start), m_pstart);
        chk("duty_active", int'(duty_active), m_active);
        chk("load_pending", int'(load_pending), m_lp);
        chk("cnt", int'(dut.r_cnt), m_pos);
    endtask

    task automatic run(input int n, input int ps);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, 0, ps, 0);
    endtask

    task automatic wait_pstart(input int budget, input int ps, input string tag);
        int found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            cyc(1, 1, 1, 0, ps, 0);
            if (period_start) found = 1;
        end
        chk(tag, found, 1);
    endtask

    task automatic wait_pos(input int pos, input int budget, input string tag);
        int found;
        found = (m_pos == pos);
        for (int i = 0; i < budget && !found; i++) begin
            cyc(1, 1, 1, 0, 0, 0);
            if (m_pos == pos) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        int highs, pulses, len, found;
        rst_n = 0; ena = 0; tick_in = 0; duty_load = 0; prescale = 0; duty_in = 0;

        // reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255));
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_duty", int'(duty_active), 0);

        // no load: pwm stays low, period_start every 255 cycles
        highs = 0; pulses = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1, 1, 1, 0, 0, 0);
            highs += int'(pwm_out);
            pulses += int'(period_start);
        end
        chk("idle_highs", highs, 0);
        chk("idle_pulses", pulses, 2);

        // duty 128
        cyc(1, 1, 1, 1, 0, 128);
        wait_pstart(300, 0, "d128_wrap");
        highs = int'(pwm_out);
        for (int i = 0; i < 254; i++) begin cyc(1, 1, 1, 0, 0, 0); highs += int'(pwm_out); end
        chk("d128_highs", highs, 128);

        // duty 0
        cyc(1, 1, 1, 1, 0, 0);
        wait_pstart(300, 0, "d0_wrap");
        highs = int'(pwm_out);
        for (int i = 0; i < 254; i++) begin cyc(1, 1, 1, 0, 0, 0); highs += int'(pwm_out); end
        chk("d0_highs", highs, 0);

        // duty 255, observed across a wrap
        cyc(1, 1, 1, 1, 0, 255);
        wait_pstart(300, 0, "d255_wrap");
        highs = int'(pwm_out);
        for (int i = 0; i < 299; i++) begin cyc(1, 1, 1, 0, 0, 0); highs += int'(pwm_out); end
        chk("d255_highs", highs, 300);

        // prescale 3, duty 10: 1020-cycle period, 40 high
        cyc(1, 1, 1, 1, 3, 10);
        wait_pstart(1100, 3, "ps3_wrap");
        highs = int'(pwm_out); len = 1; found = 0;
        for (int i = 0; i < 1100 && !found; i++) begin
            cyc(1, 1, 1, 0, 3, 0);
            if (period_start) found = 1;
            else begin len++; highs += int'(pwm_out); end
        end
        chk("ps3_found", found, 1);
        chk("ps3_len", len, 1020);
        chk("ps3_highs", highs, 40);

        // double buffer: 64 active, load 200 at cnt 50
        run(8, 3);
        cyc(1, 1, 1, 1, 0, 64);
        wait_pstart(1100, 0, "db64_wrap");
        wait_pos(50, 300, "db_pos50");
        cyc(1, 1, 1, 1, 0, 200);
        chk("db_lp_set", int'(load_pending), 1);
        chk("db_still64", int'(duty_active), 64);
        wait_pstart(300, 0, "db200_wrap");
        chk("db_now200", int'(duty_active), 200);
        chk("db_lp_clr", int'(load_pending), 0);

        // last load wins
        run(20, 0);
        cyc(1, 1, 1, 1, 0, 30);
        run(10, 0);
        cyc(1, 1, 1, 1, 0, 90);
        wait_pstart(300, 0, "lw_wrap");
        chk("last_wins", int'(duty_active), 90);

        // load on the exact wrap cycle
        wait_pos(254, 300, "wc_pos254");
        cyc(1, 1, 1, 1, 0, 77);
        chk("wrapload_duty", int'(duty_active), 77);
        chk("wrapload_lp", int'(load_pending), 0);
        chk("wrapload_ps", int'(period_start), 1);

        // enable gating at cnt 100 for 37 cycles
        wait_pos(100, 300, "en_pos100");
        len = 0;
        for (int i = 0; i < 37; i++) begin
            cyc(1, 0, 1, 0, 0, 0);
            len++;
            chk("gated_pwm", int'(pwm_out), 0);
        end
        chk("gated_cnt", int'(dut.r_cnt), 100);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cyc(1, 1, 1, 0, 0, 0);
            len++;
            if (period_start) found = 1;
        end
        chk("gated_found", found, 1);
        chk("gated_len", len, 192);

        // reset mid-period with a load pending
        wait_pos(170, 300, "mr_pos170");
        cyc(1, 1, 1, 1, 0, 150);
        wait_pos(180, 300, "mr_pos180");
        chk("mr_lp", int'(load_pending), 1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("mr_cnt", int'(dut.r_cnt), 0);
        chk("mr_duty", int'(duty_active), 0);
        chk("mr_lp_clr", int'(load_pending), 0);
        chk("mr_pwm", int'(pwm_out), 0);
        chk("mr_pstart", int'(period_start), 0);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                (($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2)),
                $urandom_range(0, 255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_core.md
# pwm_core

Duty-cycle PWM generator sitting directly downstream of the Johnson counter stage in the TinyTapeout PWM design. The counter stage supplies an advance strobe (`tick_in`), and this block turns that strobe into a programmable-period, programmable-duty `pwm_out` on a `uo_out` bit. Duty updates are double-buffered, so a new duty value takes effect only at a period boundary and never produces a runt pulse.

## Interface
- `WIDTH`, 8: width of the duty value and the period counter. Period = 2^WIDTH − 1 steps.
- `PRESCALE_W`, 4: width of the prescaler divide field.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  design enable. Low freezes the counters and forces `pwm_out` low.
- `tick_in`  in  1  advance strobe from the upstream Johnson counter stage, one cycle per tick.
- `prescale`  in  PRESCALE_W  number of extra qualified ticks per step. Sampled every cycle.
- `duty_in`  in  WIDTH  requested duty value.
- `duty_load`  in  1  single-cycle strobe that captures `duty_in` into the pending register.
- `pwm_out`  out  1  PWM output.
- `period_start`  out  1  registered one-cycle pulse marking the first cycle of each period.
- `duty_active`  out  WIDTH  duty value currently in effect.
- `load_pending`  out  1  high while a captured duty value is waiting for the next boundary.

## Operation
- **Qualified tick:** `ena && tick_in`.
- **Prescaler (`presc_cnt`, PRESCALE_W bits):**
  - On a qualified tick with `presc_cnt == prescale`: assert internal `step` and clear `presc_cnt`.
  - On any other qualified tick: increment `presc_cnt`.
  - With `prescale = 0`, every qualified tick is a step.
  - If `prescale` is lowered below `presc_cnt`, the next qualified tick is a step (compare is ≥).
- **Period counter (`cnt`, WIDTH bits):**
  - On `step`, count 0 .. 2^WIDTH − 2. At 2^WIDTH − 2, wrap to 0 (`wrap` event).
  - For WIDTH = 8 the counter runs 0..254 and never reaches 255.
- **Output:** `pwm_out = ena && (cnt < duty_active)`, combinational from flops only.
  - `duty_active = 0`: constantly low.
  - `duty_active = 2^WIDTH − 1`: constantly high while `ena` is high.
- **Duty update (double-buffered):**
  - `duty_load` writes `duty_in` into `pending` and sets `load_pending`.
  - A later load before the boundary overwrites `pending`; the last one wins.
  - On `wrap` with `load_pending` set: `duty_active <= pending` and `load_pending` clears.
  - `duty_load` and `wrap` in the same cycle: `duty_active <= duty_in` directly and `load_pending` clears.
  - Loads are accepted regardless of `ena`.
- **`period_start`:** `period_start <= wrap`. It is high exactly in the first cycle that `cnt == 0` after a wrap, and is not asserted after reset.
- **`ena` low:** `presc_cnt`, `cnt`, and `duty_active` hold, and `pwm_out` is 0. Operation resumes from the held state when `ena` returns high.

## Timing
- **Reset** (`rst_n` low at a rising edge; wins over all other inputs, including mid-period):
  - `cnt = 0`, `presc_cnt = 0`, `pending = 0`, `duty_active = 0`, `load_pending = 0`.
  - `period_start = 0`, `pwm_out = 0`.
- **Step latency:** `cnt` changes on the edge that samples the qualifying tick. `pwm_out` reflects the new `cnt` in the same cycle as the new register value (0-cycle combinational path after the flop).
- **Load latency:** `duty_load` at edge N gives `load_pending = 1` after edge N. The new duty applies after the edge that performs the next wrap.
- **Period length:** (2^WIDTH − 1) × (`prescale` + 1) qualified ticks. With a tick every cycle and `prescale = 0`, that is 255 clocks.
- **High time per period:** `duty_active` × (`prescale` + 1) qualified ticks.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles with random inputs → all outputs 0. Release with `ena = 1`, `tick_in = 1`, no load → `pwm_out` stays 0 for 600 cycles; `period_start` pulses every 255 cycles.
- **Basic duty:** load duty 128 (`prescale = 0`, tick every cycle) → after the first wrap, each 255-cycle period has exactly 128 high cycles starting at `period_start`, then 127 low cycles.
- **Extremes and prescale:**
  - duty 0 → `pwm_out` never high.
  - duty 255 → `pwm_out` continuously high across wraps.
  - `prescale = 3`, duty 10 → period 1020 cycles with 40 high.
- **Double-buffer:**
  - Load 200 at `cnt = 50` while `duty_active = 64` → rest of the period still uses 64; `load_pending = 1` until the wrap, then 200.
  - Load 30 then 90 in the same period → 90 applies.
  - Load on the exact wrap cycle → applies immediately.
- **Enable gating:** drop `ena` for 37 cycles at `cnt = 100` → `pwm_out = 0` and `cnt` holds at 100. On re-enable, counting continues from 100, and the period completes 37 cycles later than ungated.
- **Reset mid-operation:** assert `rst_n = 0` for one cycle at `cnt = 180` with `load_pending = 1` → next cycle `cnt = 0`, `duty_active = 0`, `load_pending = 0`, `pwm_out = 0`, and no `period_start` pulse.
